fetch_unit: RTL and testbench

Instruction fetch stage of the femtoRV32 pipeline. Holds the PC, issues word requests to instruction memory over a ready-based handshake, and presents the fetched instruction with its PC in the IF/ID register that feeds the control unit and decoder. Handles pipeline stall, redirect (branch/jump) and ebreak halt. Memory latency is variable, so in-flight responses are drained or buffered as required.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 53 +++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared constants and state encodings for the fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] c_WORD_INCR = 32'd4;

    localparam int          c_STATE_W   = 2;
    localparam logic [1:0]  c_ST_FETCH  = 2'd0;
    localparam logic [1:0]  c_ST_BUF    = 2'd1;
    localparam logic [1:0]  c_ST_DRAIN  = 2'd2;
    localparam logic [1:0]  c_ST_HALT   = 2'd3;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + c_WORD_INCR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : Pipeline register holding instruction, PC and PC+4; flush wins.
// Revision : 1.0
// ============================================================================
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst     <= NOP_INST;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= next_word(RESET_PC);
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_inst     <= i_inst;
            r_pc       <= i_pc;
            r_pc_plus4 <= next_word(i_pc);
            r_valid    <= 1'b1;
        end
    end

    assign o_inst     = r_inst;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : femtoRV32 instruction fetch with skid buffer, drain and halt.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_INST = c_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted
);

    logic [c_STATE_W-1:0] r_state;
    logic [31:0]          r_pc;
    logic [31:0]          r_pend_pc;
    logic                 r_halt_pending;
    logic [31:0]          r_skid_inst;

    logic [31:0]          w_target;
    logic                 w_load;
    logic                 w_flush;
    logic [31:0]          w_ld_inst;

    assign w_target = redirect_pc & ~32'd3;

    // In BUF the PC has not advanced, so the skid entry's PC is r_pc itself.
    always_comb begin
        w_load    = 1'b0;
        w_flush   = 1'b0;
        w_ld_inst = imem_rdata;
        case (r_state)
            c_ST_FETCH: begin
                if (redirect)
                    w_flush = 1'b1;
                else if (!halt && imem_ready && !stall)
                    w_load = 1'b1;
            end
            c_ST_BUF: begin
                w_ld_inst = r_skid_inst;
                if (redirect)
                    w_flush = 1'b1;
                else if (!halt && !stall)
                    w_load = 1'b1;
            end
            c_ST_DRAIN: begin
                if (redirect)
                    w_flush = 1'b1;
            end
            default: begin
                w_load  = 1'b0;
                w_flush = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_FETCH;
            r_pc           <= RESET_PC;
            r_pend_pc      <= RESET_PC;
            r_halt_pending <= 1'b0;
            r_skid_inst    <= NOP_INST;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    if (redirect) begin
                        r_halt_pending <= 1'b0;
                        if (imem_ready) begin
                            r_pc <= w_target;
                        end else begin
                            r_pend_pc <= w_target;
                            r_state   <= c_ST_DRAIN;
                        end
                    end else if (halt) begin
                        if (imem_ready) begin
                            r_state <= c_ST_HALT;
                        end else begin
                            r_halt_pending <= 1'b1;
                            r_state        <= c_ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            r_skid_inst <= imem_rdata;
                            r_state     <= c_ST_BUF;
                        end else begin
                            r_pc <= next_word(r_pc);
                        end
                    end
                end
                c_ST_BUF: begin
                    if (redirect) begin
                        r_pc    <= w_target;
                        r_state <= c_ST_FETCH;
                    end else if (halt) begin
                        r_state <= c_ST_HALT;
                    end else if (!stall) begin
                        r_pc    <= next_word(r_pc);
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_DRAIN: begin
                    if (redirect) begin
                        r_pend_pc      <= w_target;
                        r_halt_pending <= 1'b0;
                    end else if (halt) begin
                        r_halt_pending <= 1'b1;
                    end
                    // A redirect landing on the completing cycle supplies the next PC directly.
                    if (imem_ready) begin
                        r_pc    <= redirect ? w_target : r_pend_pc;
                        r_state <= (!redirect && (halt || r_halt_pending)) ? c_ST_HALT : c_ST_FETCH;
                    end
                end
                c_ST_HALT: begin
                    r_state <= c_ST_HALT;
                end
                default: begin
                    r_state <= c_ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = !rst && ((r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN));
    assign imem_addr = r_pc;
    assign halted    = (r_state == c_ST_HALT);

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_inst     (w_ld_inst),
        .i_pc       (r_pc),
        .o_inst     (if_inst),
        .o_pc       (if_pc),
        .o_pc_plus4 (if_pc_plus4),
        .o_valid    (if_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_SALT = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory content is derived from the address so every word is distinguishable.
    assign imem_rdata = imem_addr ^ c_SALT;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        @(posedge clk); @(posedge clk); tick();

        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_inst",   if_inst, c_NOP);
        chk("rst_pc",     if_pc, 32'h0);
        chk("rst_pc4",    if_pc_plus4, 32'h4);
        chk("rst_valid",  {31'd0, if_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;

        // Zero-wait streaming
        tick();
        chk("zw0_valid", {31'd0, if_valid}, 32'd1);
        chk("zw0_pc",    if_pc, 32'h0);
        chk("zw0_inst",  if_inst, 32'h0 ^ c_SALT);
        chk("zw0_pc4",   if_pc_plus4, 32'h4);
        tick(); chk("zw1_pc", if_pc, 32'h4);
        tick(); chk("zw2_pc", if_pc, 32'h8);
        tick(); chk("zw3_pc", if_pc, 32'hC);
        chk("zw3_addr", imem_addr, 32'h10);

        // Ready delayed three cycles
        imem_ready = 1'b0;
        tick(); chk("dly0_pc", if_pc, 32'hC); chk("dly0_addr", imem_addr, 32'h10);
        chk("dly0_req", {31'd0, imem_req}, 32'd1);
        tick(); chk("dly1_addr", imem_addr, 32'h10);
        tick(); chk("dly2_pc", if_pc, 32'hC); chk("dly2_addr", imem_addr, 32'h10);
        imem_ready = 1'b1;
        tick(); imem_ready = 1'b0;
        chk("dly_pc",   if_pc, 32'h10);
        chk("dly_inst", if_inst, 32'h10 ^ c_SALT);
        chk("dly_addr", imem_addr, 32'h14);

        // Stall for four edges while the response for 0x14 arrives
        imem_ready = 1'b1; stall = 1'b1;
        tick(); chk("stl0_pc", if_pc, 32'h10); chk("stl0_req", {31'd0, imem_req}, 32'd0);
        tick(); chk("stl1_pc", if_pc, 32'h10);
        tick(); chk("stl2_inst", if_inst, 32'h10 ^ c_SALT);
        tick(); chk("stl3_pc", if_pc, 32'h10);
        stall = 1'b0;
        tick();
        chk("rel_pc",   if_pc, 32'h14);
        chk("rel_inst", if_inst, 32'h14 ^ c_SALT);
        chk("rel_addr", imem_addr, 32'h18);
        tick();
        chk("rel_next_pc", if_pc, 32'h18);

        // Redirect while a request is outstanding
        imem_ready = 1'b0;
        tick(); chk("drn_pre_addr", imem_addr, 32'h1C);
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        tick(); redirect = 1'b0;
        chk("drn_valid", {31'd0, if_valid}, 32'd0);
        chk("drn_inst",  if_inst, c_NOP);
        chk("drn_addr",  imem_addr, 32'h1C);
        chk("drn_req",   {31'd0, imem_req}, 32'd1);
        imem_ready = 1'b1;
        tick();
        chk("drn_new_addr", imem_addr, 32'h100);
        chk("drn_discard",  {31'd0, if_valid}, 32'd0);
        tick();
        chk("tgt_valid", {31'd0, if_valid}, 32'd1);
        chk("tgt_pc",    if_pc, 32'h100);
        chk("tgt_inst",  if_inst, 32'h100 ^ c_SALT);

        // Redirect coinciding with ready, then wrap at the top of memory
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); redirect = 1'b0;
        chk("wrp_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("wrp_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("wrp_pc",   if_pc, 32'hFFFF_FFFC);
        chk("wrp_pc4",  if_pc_plus4, 32'h0);
        chk("wrp_next", imem_addr, 32'h0);

        // Halt during zero-wait fetch; redirect must be ignored afterwards
        halt = 1'b1;
        tick(); halt = 1'b0;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_req",    {31'd0, imem_req}, 32'd0);
        chk("hlt_pc",     if_pc, 32'hFFFF_FFFC);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick(); redirect = 1'b0;
        chk("hlt_rd_halted", {31'd0, halted}, 32'd1);
        chk("hlt_rd_valid",  {31'd0, if_valid}, 32'd1);
        chk("hlt_rd_pc",     if_pc, 32'hFFFF_FFFC);
        chk("hlt_rd_req",    {31'd0, imem_req}, 32'd0);

        // Reset recovers from HALT
        rst = 1'b1;
        tick();
        chk("rr_req",    {31'd0, imem_req}, 32'd0);
        chk("rr_halted", {31'd0, halted}, 32'd0);
        chk("rr_pc",     if_pc, 32'h0);
        chk("rr_valid",  {31'd0, if_valid}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rr_fetch_pc",    if_pc, 32'h0);
        chk("rr_fetch_valid", {31'd0, if_valid}, 32'd1);
        chk("rr_fetch_addr",  imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
